barrel_unrotator: RTL and testbench
===================================

Name: barrel_unrotator

Overview:
- Sequential inverse of the team's registered right-rotate barrel shifter. It sits on the receive side of the rotate-encoded data path.
- Mode 0 (undo): rotates a captured word left by a known amount, one position per cycle, and recovers the original word.
- Mode 1 (align): finds the rotation amount by rotating left until the word equals a supplied sync pattern.
- Start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 8, data word width in bits.
- SHW, 3, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- mode  input  1  0 = undo known shift, 1 = search for pattern.
- data_in  input  WIDTH  rotated word, sampled on accepted start.
- shift  input  SHW  known right-rotate amount (mode 0), sampled on accepted start.
- pattern  input  WIDTH  sync pattern (mode 1), sampled on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- found  output  1  mode 1: pattern matched. Always 1 after a mode 0 operation.
- data_out  output  WIDTH  recovered word, held until the next completion.
- shift_out  output  SHW  rotation amount undone: shift in mode 0, match distance in mode 1, 0 on no match.

Behaviour:
- Reset (clear=1, asynchronous): state IDLE. busy, done, found = 0. data_out, shift_out = 0. Internal word, counter and captured pattern = 0.
- States:
  - IDLE: busy=0.
  - ROT: busy=1.
- Start handling:
  - start=1 in IDLE at edge k: capture data_in, shift, pattern and mode; clear the rotation counter n; go to ROT.
  - start while busy=1 is ignored. No queuing, no error flag.
- ROT, mode 0:
  - While n<shift: word <= rotl1(word), n <= n+1.
  - When n==shift: data_out <= word, shift_out <= shift, found <= 1, done pulse, go to IDLE.
  - Latency: done is high in the cycle after edge k+shift+1. shift=0 gives done after edge k+1 with data_out = data_in.
- ROT, mode 1 (compare each ROT cycle):
  - If word==pattern: data_out <= word, shift_out <= n, found <= 1, done, go to IDLE. The smallest matching n wins.
  - Else if n==WIDTH-1: word <= rotl1(word), then data_out <= rotl1(word) (the original word), shift_out <= 0, found <= 0, done, go to IDLE. Done lands at edge k+WIDTH.
  - Else: word <= rotl1(word), n <= n+1.
- rotl1(x) = {x[WIDTH-2:0], x[WIDTH-1]}. The counter is SHW+1 bits wide so no wrap occurs.
- done goes high exactly once per accepted start and is deasserted the following cycle.
- start may be asserted in the same cycle done is high (busy=0). It is accepted, which gives back-to-back operation.
- data_out, shift_out and found change only on a done edge or on reset.
- clear during ROT aborts the operation: outputs go to reset values, and no done is generated for the aborted operation.
- Inputs other than start are don't-care when not sampled.

Decomposition:
- Shared package holds:
  - WIDTH and SHW defaults, shared with barrel shifter instances.
  - State encoding localparams IDLE=1'b0, ROT=1'b1.
- One natural sub-module: rotl1_step, a combinational single-position left rotate parameterised by WIDTH. It is reused by the datapath and by the bench reference model.
- Everything else lives in one always block plus an output register block.

Test Plan:
- Reset: clear=1 mid-ROT -> busy=0, done=0, found=0, data_out=8'h00, shift_out=0; no done pulse after clear is released.
- Mode 0: data_in=8'hB4, shift=3, start at edge k -> done after edge k+4, data_out=8'hA5, shift_out=3, found=1.
- Mode 0, zero shift: data_in=8'h3C, shift=0 -> done after edge k+1, data_out=8'h3C.
- Mode 1 match: data_in=8'hB4, pattern=8'hA5 -> done after edge k+4, found=1, shift_out=3, data_out=8'hA5. Separately, data_in=8'h55, pattern=8'hAA -> shift_out=1 (smallest match).
- Mode 1 no match: data_in=8'h0F, pattern=8'h01 -> done after edge k+8, found=0, shift_out=0, data_out=8'h0F.
- Handshake: start held high during ROT -> ignored. Start in the done cycle -> accepted. Two back-to-back ops give exactly two done pulses, each with correct results.

Source files
------------

// File: rtl/barrel_unrotator_pkg.sv
// Shared widths and FSM encoding for the rotate-encoded receive path.
// Defaults match the transmit-side barrel shifter instances.
package barrel_unrotator_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SHW_DEF   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_t;
endpackage

// File: rtl/barrel_unrotator_rotl1.sv
// Single-position combinational left rotate; one step of the unrotator datapath.
module rotl1_step
  import barrel_unrotator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = {x_i[WIDTH-2:0], x_i[WIDTH-1]};
endmodule

// File: rtl/barrel_unrotator.sv
// Sequential inverse of the right-rotate barrel shifter: undoes a known rotation
// (mode 0) or searches for the rotation that yields a sync pattern (mode 1).
module barrel_unrotator
  import barrel_unrotator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shift_out
);
  // Counter carries one extra bit so reaching WIDTH-1 never wraps.
  localparam logic [SHW:0] LAST_N = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] ONE_N  = (SHW+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [SHW-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SHW-1:0]   shift_out_q, shift_out_d;
  logic             found_q, found_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] word_rot;

  rotl1_step #(.WIDTH(WIDTH)) u_rotl1 (
    .x_i(word_q),
    .y_o(word_rot)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pat_d       = pat_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    shift_out_d = shift_out_q;
    found_d     = found_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = data_in;
          shift_d = shift;
          pat_d   = pattern;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        if (!mode_q) begin
          if (cnt_q == {1'b0, shift_q}) begin
            data_out_d  = word_q;
            shift_out_d = shift_q;
            found_d     = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            word_d = word_rot;
            cnt_d  = cnt_q + ONE_N;
          end
        end else if (word_q == pat_q) begin
          data_out_d  = word_q;
          shift_out_d = cnt_q[SHW-1:0];
          found_d     = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == LAST_N) begin
          // One more step brings the word back to what was captured.
          word_d      = word_rot;
          data_out_d  = word_rot;
          shift_out_d = '0;
          found_d     = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          word_d = word_rot;
          cnt_d  = cnt_q + ONE_N;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      pat_q       <= '0;
      mode_q      <= 1'b0;
      data_out_q  <= '0;
      shift_out_q <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      data_out_q  <= data_out_d;
      shift_out_q <= shift_out_d;
      found_q     <= found_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == ROT);
  assign done      = done_q;
  assign found     = found_q;
  assign data_out  = data_out_q;
  assign shift_out = shift_out_q;
endmodule

// File: tb/tb_barrel_unrotator.sv
// Randomized scoreboard bench for barrel_unrotator against a rotate-arithmetic model.
module tb_barrel_unrotator;
  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic       mode;
  logic [7:0] data_in;
  logic [2:0] shift;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] data_out;
  logic [2:0] shift_out;

  typedef struct {
    logic [7:0] data;
    logic [2:0] sh;
    logic       found;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   txn   = 0;

  barrel_unrotator #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .clear(clear), .start(start), .mode(mode),
    .data_in(data_in), .shift(shift), .pattern(pattern),
    .busy(busy), .done(done), .found(found),
    .data_out(data_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!clear && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: data_out=%02h shift_out=%0d found=%0d cycle=%0d",
                 txn, data_out, shift_out, found, cyc);
        chk("data_out", int'(data_out), int'(e.data));
        chk("shift_out", int'(shift_out), int'(e.sh));
        chk("found", int'(found), int'(e.found));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input logic m, input logic [7:0] din, input logic [2:0] sh,
                       input logic [7:0] pat, input int hold);
    int   guard;
    exp_t e;
    int   lat;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_timeout: got=1 expected=0 (cycle %0d)", cyc);
    end
    if (!m) begin
      e.data = rotl(din, int'(sh)); e.sh = sh; e.found = 1'b1; lat = int'(sh) + 1;
    end else begin
      e.data = din; e.sh = 3'd0; e.found = 1'b0; lat = 8;
      for (int n = 7; n >= 0; n--) begin
        if (rotl(din, n) == pat) begin
          e.data = pat; e.sh = 3'(n); e.found = 1'b1; lat = n + 1;
        end
      end
    end
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    mode = m; data_in = din; shift = sh; pattern = pat; start = 1'b1;
    @(posedge clk); #1;
    repeat (hold) begin
      mode = 1'($urandom); data_in = 8'($urandom); shift = 3'($urandom);
      pattern = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_data_out"}, int'(data_out), 0);
    chk({tag, "_shift_out"}, int'(shift_out), 0);
  endtask

  initial begin
    int guard;
    clear = 1'b1; start = 1'b0; mode = 1'b0;
    data_in = '0; shift = '0; pattern = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clear = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 8'hB4, 3'd3, 8'h00, 0);
    do_op(1'b0, 8'h3C, 3'd0, 8'h00, 0);
    do_op(1'b1, 8'hB4, 3'd0, 8'hA5, 0);
    do_op(1'b1, 8'h55, 3'd0, 8'hAA, 0);
    do_op(1'b1, 8'h0F, 3'd0, 8'h01, 0);
    do_op(1'b0, 8'hC3, 3'd5, 8'h00, 4);
    do_op(1'b1, 8'h81, 3'd0, 8'h03, 0);
    do_op(1'b0, 8'h96, 3'd7, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      logic       m;
      logic [7:0] din;
      logic [7:0] pat;
      m   = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      if (m && $urandom_range(0, 1) == 1) pat = rotl(din, int'($urandom_range(0, 7)));
      else pat = 8'($urandom);
      do_op(m, din, 3'($urandom), pat, 0);
    end

    // Abort a long operation mid-flight; no done may follow.
    do_op(1'b0, 8'h5A, 3'd7, 8'h00, 0);
    repeat (2) @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_abort_busy", int'(busy), 0);

    do_op(1'b0, 8'hB4, 3'd3, 8'h00, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got=%0d pending expected=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
